// File: rtl/touch_adc_spi.sv
// Touch-screen ADC controller: debounces pen-down, then repeatedly runs X/Y
// 24-clock SPI conversion frames and publishes the coordinates with a strobe.
module touch_adc_spi #(
    parameter int unsigned CLK_DIV  = 25,
    parameter int unsigned DEBOUNCE = 1000,
    parameter int unsigned GAP      = 5000
) (
    input  logic       sys_clk,
    input  logic       iRST_n,
    input  logic       adc_penirq_n,
    input  logic       adc_dout,
    output logic       adc_cs_n,
    output logic       adc_dclk,
    output logic       adc_din,
    output logic [7:0] x_in,
    output logic [9:0] y_in,
    output logic       new_coord_r,
    output logic       penirq_n,
    output logic       transmit_en
);

    localparam int unsigned CNT_MAX = (DEBOUNCE > GAP) ? DEBOUNCE : GAP;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned DIV_W   = 8;
    localparam int unsigned PH_W    = 6;
    // Phase 0 is the CS-to-first-rise lead, odd phases dclk high, even low;
    // phase 48 is the trailing low half, 49 is the CS-high gap before Y.
    localparam logic [PH_W-1:0] PH_LAST  = PH_W'(48);
    localparam logic [PH_W-1:0] PH_CSGAP = PH_W'(49);
    localparam logic [7:0]      CMD_X    = 8'hD0;
    localparam logic [7:0]      CMD_Y    = 8'h90;

    typedef enum logic [2:0] {
        ST_IDLE, ST_DEBOUNCE, ST_FRAME_X, ST_FRAME_Y, ST_UPDATE, ST_GAP
    } state_e;

    state_e            state_q, state_d;
    logic [1:0]        pen_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [PH_W-1:0]   ph_q, ph_d, ph_nx;
    logic [11:0]       shreg_q, shreg_d;
    logic [7:0]        xhold_q, xhold_d;
    logic [7:0]        x_q, x_d;
    logic [9:0]        y_q, y_d;
    logic              cs_q, cs_d, dclk_q, dclk_d, din_q, din_d;
    logic              newc_q, newc_d, tx_q, tx_d;
    logic [7:0]        cmd;

    // Two-flop synchroniser for the raw pen interrupt.
    always_ff @(posedge sys_clk or negedge iRST_n) begin
        if (!iRST_n) pen_q <= 2'b11;
        else         pen_q <= {pen_q[0], adc_penirq_n};
    end

    always_ff @(posedge sys_clk or negedge iRST_n) begin
        if (!iRST_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            div_q   <= '0;
            ph_q    <= '0;
            shreg_q <= '0;
            xhold_q <= '0;
            x_q     <= '0;
            y_q     <= '0;
            cs_q    <= 1'b1;
            dclk_q  <= 1'b0;
            din_q   <= 1'b0;
            newc_q  <= 1'b0;
            tx_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            ph_q    <= ph_d;
            shreg_q <= shreg_d;
            xhold_q <= xhold_d;
            x_q     <= x_d;
            y_q     <= y_d;
            cs_q    <= cs_d;
            dclk_q  <= dclk_d;
            din_q   <= din_d;
            newc_q  <= newc_d;
            tx_q    <= tx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        ph_d    = ph_q;
        shreg_d = shreg_q;
        xhold_d = xhold_q;
        x_d     = x_q;
        y_d     = y_q;
        cs_d    = cs_q;
        dclk_d  = dclk_q;
        din_d   = din_q;
        newc_d  = 1'b0;
        tx_d    = tx_q;
        ph_nx   = ph_q + PH_W'(1);
        cmd     = (state_q == ST_FRAME_Y) ? CMD_Y : CMD_X;

        case (state_q)
            ST_IDLE: begin
                if (!pen_q[1]) begin
                    state_d = ST_DEBOUNCE;
                    cnt_d   = '0;
                end
            end
            ST_DEBOUNCE: begin
                if (pen_q[1]) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_W'(DEBOUNCE - 1)) begin
                    state_d = ST_FRAME_X;
                    tx_d    = 1'b1;
                    cs_d    = 1'b0;
                    dclk_d  = 1'b0;
                    din_d   = CMD_X[7];
                    div_d   = '0;
                    ph_d    = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_FRAME_X, ST_FRAME_Y: begin
                if (div_q == DIV_W'(CLK_DIV - 1)) begin
                    div_d = '0;
                    ph_d  = ph_nx;
                    if (ph_nx <= PH_LAST) begin
                        dclk_d = ph_nx[0];
                        if (ph_nx[0]) begin
                            // Rising edge: capture conversion bits of periods 10..21.
                            if (ph_nx >= PH_W'(19) && ph_nx <= PH_W'(41))
                                shreg_d = {shreg_q[10:0], adc_dout};
                        end else begin
                            din_d = (ph_nx <= PH_W'(14))
                                  ? cmd[3'(PH_W'(7) - (ph_nx >> 1))] : 1'b0;
                        end
                    end else if (ph_nx == PH_CSGAP) begin
                        cs_d   = 1'b1;
                        dclk_d = 1'b0;
                        din_d  = 1'b0;
                        if (state_q == ST_FRAME_Y) begin
                            state_d = ST_UPDATE;
                            ph_d    = '0;
                            x_d     = xhold_q;
                            y_d     = shreg_q[11:2];
                            newc_d  = 1'b1;
                        end else begin
                            xhold_d = shreg_q[11:4];
                        end
                    end else begin
                        state_d = ST_FRAME_Y;
                        ph_d    = '0;
                        cs_d    = 1'b0;
                        din_d   = CMD_Y[7];
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            ST_UPDATE: begin
                state_d = ST_GAP;
                cnt_d   = '0;
            end
            ST_GAP: begin
                if (cnt_q == CNT_W'(GAP - 1)) begin
                    if (!pen_q[1]) begin
                        state_d = ST_FRAME_X;
                        cs_d    = 1'b0;
                        dclk_d  = 1'b0;
                        din_d   = CMD_X[7];
                        div_d   = '0;
                        ph_d    = '0;
                    end else begin
                        state_d = ST_IDLE;
                        tx_d    = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign adc_cs_n    = cs_q;
    assign adc_dclk    = dclk_q;
    assign adc_din     = din_q;
    assign x_in        = x_q;
    assign y_in        = y_q;
    assign new_coord_r = newc_q;
    assign penirq_n    = pen_q[1];
    assign transmit_en = tx_q;

endmodule

// File: tb/tb_touch_adc_spi.sv
// Scoreboard bench for touch_adc_spi: an ADC model answers each frame from the
// decoded command; a monitor checks frames, strobes and transmit_en edges.
module tb_touch_adc_spi;

    localparam int unsigned CLK_DIV  = 2;
    localparam int unsigned DEBOUNCE = 8;
    localparam int unsigned GAP      = 16;

    logic       sys_clk = 1'b0;
    logic       iRST_n;
    logic       adc_penirq_n;
    logic       adc_dout;
    logic       adc_cs_n, adc_dclk, adc_din;
    logic [7:0] x_in;
    logic [9:0] y_in;
    logic       new_coord_r, penirq_n, transmit_en;

    touch_adc_spi #(.CLK_DIV(CLK_DIV), .DEBOUNCE(DEBOUNCE), .GAP(GAP)) dut (
        .sys_clk      (sys_clk),
        .iRST_n       (iRST_n),
        .adc_penirq_n (adc_penirq_n),
        .adc_dout     (adc_dout),
        .adc_cs_n     (adc_cs_n),
        .adc_dclk     (adc_dclk),
        .adc_din      (adc_din),
        .x_in         (x_in),
        .y_in         (y_in),
        .new_coord_r  (new_coord_r),
        .penirq_n     (penirq_n),
        .transmit_en  (transmit_en)
    );

    always #5 sys_clk = ~sys_clk;

    int n_checks = 0, n_fail = 0;
    int cyc = 0;
    int strobes = 0, strobe_cyc = 0;
    int tx_rises = 0, tx_falls = 0, tx_fall_cyc = 0;
    int cs_falls = 0, cs_fall_cyc = 0;
    int rises = 0;
    logic [23:0] din_sh = '0;
    logic [7:0]  cmd_q = '0;
    logic        expect_x = 1'b1;
    logic        prev_cs = 1'b1, prev_dclk = 1'b0, prev_newc = 1'b0, prev_tx = 1'b0;
    logic [11:0] xv = '0, yv = '0;
    logic [17:0] exp_q[$];
    logic [17:0] e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    always @(posedge sys_clk) cyc++;

    // ADC model: returns the 12-bit result for the decoded command, MSB first.
    always_comb begin
        adc_dout = 1'b0;
        if (rises >= 9 && rises <= 20)
            adc_dout = (cmd_q == 8'hD0) ? xv[20 - rises] : yv[20 - rises];
    end

    // Monitor: frame shape, din pattern, coordinate scoreboard, transmit_en edges.
    always @(negedge sys_clk) begin
        if (prev_cs && !adc_cs_n) begin
            cs_falls++;
            cs_fall_cyc = cyc;
            rises = 0;
            din_sh = '0;
        end
        if (!adc_cs_n && !prev_dclk && adc_dclk) begin
            din_sh = {din_sh[22:0], adc_din};
            rises++;
            if (rises == 8) cmd_q = din_sh[7:0];
        end
        if (!prev_cs && adc_cs_n) begin
            if (!iRST_n) begin
                expect_x = 1'b1;
            end else begin
                check("frame_rises", rises, 24);
                check(expect_x ? "din_x" : "din_y", 32'(din_sh),
                      expect_x ? 32'h00D00000 : 32'h00900000);
                expect_x = !expect_x;
            end
            rises = 0;
        end
        if (new_coord_r) begin
            strobes++;
            strobe_cyc = cyc;
            check("strobe_width", 32'(prev_newc), 0);
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("x_in", 32'(x_in), 32'(e[17:10]));
                check("y_in", 32'(y_in), 32'(e[9:0]));
            end
            check("tx_at_strobe", 32'(transmit_en), 1);
        end
        if (!prev_tx && transmit_en) tx_rises++;
        if (prev_tx && !transmit_en) begin
            tx_falls++;
            tx_fall_cyc = cyc;
        end
        prev_cs   = adc_cs_n;
        prev_dclk = adc_dclk;
        prev_newc = new_coord_r;
        prev_tx   = transmit_en;
    end

    function automatic int cnt_of(input int which);
        case (which)
            0:       return strobes;
            1:       return tx_falls;
            2:       return cs_falls;
            default: return rises;
        endcase
    endfunction

    task automatic wait_for(input int which, input int target, input int budget, input string name);
        int n = 0;
        while (cnt_of(which) < target && n < budget) begin
            @(negedge sys_clk);
            #1;
            n++;
        end
        check(name, 32'(cnt_of(which) >= target), 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cs_n"},   32'(adc_cs_n), 1);
        check({tag, "_dclk"},   32'(adc_dclk), 0);
        check({tag, "_din"},    32'(adc_din), 0);
        check({tag, "_tx"},     32'(transmit_en), 0);
        check({tag, "_newc"},   32'(new_coord_r), 0);
        check({tag, "_x"},      32'(x_in), 0);
        check({tag, "_y"},      32'(y_in), 0);
        check({tag, "_penirq"}, 32'(penirq_n), 1);
    endtask

    initial begin
        int base, t_rel;
        iRST_n = 1'b0;
        adc_penirq_n = 1'b1;
        repeat (3) @(posedge sys_clk);
        #1 check_reset_outputs("por");
        @(negedge sys_clk);
        iRST_n = 1'b1;

        // Short pen press must not start a session.
        repeat (3) @(negedge sys_clk);
        adc_penirq_n = 1'b0;
        repeat (5) @(negedge sys_clk);
        adc_penirq_n = 1'b1;
        repeat (40) @(negedge sys_clk);
        #1;
        check("short_pen_cs", 32'(cs_falls), 0);
        check("short_pen_tx", 32'(transmit_en), 0);

        // Continuous touch: three pairs, pen released mid third Y frame.
        xv = 12'hABC;
        yv = 12'h5A5;
        repeat (3) exp_q.push_back({8'hAB, 10'h169});
        adc_penirq_n = 1'b0;
        wait_for(0, 2, 2000, "wait_two_pairs");
        check("tx_held", 32'(tx_falls), 0);
        wait_for(2, 6, 2000, "wait_third_y");
        repeat (30) @(negedge sys_clk);
        adc_penirq_n = 1'b1;
        wait_for(0, 3, 1000, "wait_third_pair");
        wait_for(1, 1, 1000, "wait_tx_fall");
        check("tx_fall_delay", 32'(tx_fall_cyc - strobe_cyc), GAP + 1);
        repeat (20) @(negedge sys_clk);
        #1;
        check("hold_x", 32'(x_in), 32'h00AB);
        check("hold_y", 32'(y_in), 32'h0169);
        check("tx_one_rise", 32'(tx_rises), 1);

        // Full-scale and zero results.
        xv = 12'hFFF;
        yv = 12'hFFF;
        exp_q.push_back({8'hFF, 10'h3FF});
        adc_penirq_n = 1'b0;
        wait_for(0, 4, 2000, "wait_full_scale");
        adc_penirq_n = 1'b1;
        wait_for(1, 2, 1000, "wait_fs_end");
        xv = 12'h000;
        yv = 12'h000;
        exp_q.push_back({8'h00, 10'h000});
        adc_penirq_n = 1'b0;
        wait_for(0, 5, 2000, "wait_zero");
        adc_penirq_n = 1'b1;
        wait_for(1, 3, 1000, "wait_zero_end");

        // Reset in the middle of an X frame, then a full debounce before the next frame.
        base = cs_falls;
        adc_penirq_n = 1'b0;
        wait_for(2, base + 1, 1000, "wait_abort_frame");
        wait_for(3, 15, 500, "wait_period15");
        #2 iRST_n = 1'b0;
        #1 check_reset_outputs("midrst");
        xv = 12'hABC;
        yv = 12'h5A5;
        repeat (3) @(negedge sys_clk);
        iRST_n = 1'b1;
        t_rel = cyc;
        base = cs_falls;
        exp_q.push_back({8'hAB, 10'h169});
        wait_for(2, base + 1, 500, "wait_post_rst_frame");
        check("post_rst_debounce", 32'(cs_fall_cyc - t_rel), DEBOUNCE + 3);
        wait_for(0, 6, 2000, "wait_post_rst_pair");
        adc_penirq_n = 1'b1;
        wait_for(1, 5, 1000, "wait_final_end");
        check("queue_empty", 32'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
        $fatal(1);
    end

endmodule

// File: doc/touch_adc_spi.md
TOUCH_ADC_SPI -- requirements
Module: touch_adc_spi

Interface
REQ-001 SHALL have parameter CLK_DIV, default 25: sys_clk cycles per adc_dclk half-period, legal range 2..255.
REQ-002 SHALL have parameter DEBOUNCE, default 1000: sys_clk cycles pen must stay down before a session starts.
REQ-003 SHALL have parameter GAP, default 5000: idle sys_clk cycles between coordinate pairs within one session.
REQ-004 SHALL have port sys_clk, in, 1: single clock; all logic on its rising edge.
REQ-005 SHALL have port iRST_n, in, 1: reset, asynchronous and active-low.
REQ-006 SHALL have port adc_penirq_n, in, 1: raw pen-down from the touch ADC, low = pressed.
REQ-007 SHALL have port adc_dout, in, 1: serial data from the ADC.
REQ-008 SHALL have port adc_cs_n, out, 1: ADC chip select, active-low.
REQ-009 SHALL have port adc_dclk, out, 1: ADC serial clock.
REQ-010 SHALL have port adc_din, out, 1: serial command to the ADC.
REQ-011 SHALL have port x_in, out, 8: latest X coordinate, feeds touch x_in.
REQ-012 SHALL have port y_in, out, 10: latest Y coordinate, feeds touch y_in.
REQ-013 SHALL have port new_coord_r, out, 1: one-cycle strobe when x_in/y_in update.
REQ-014 SHALL have port penirq_n, out, 1: adc_penirq_n after two sys_clk flops.
REQ-015 SHALL have port transmit_en, out, 1: high for the whole touch session.

Function
REQ-016 SHALL implement states IDLE, DEBOUNCE, FRAME_X, FRAME_Y, UPDATE, GAP.
REQ-017 IDLE: on penirq_n=0, SHALL go to DEBOUNCE and clear the debounce counter.
REQ-018 DEBOUNCE: penirq_n=1 on any cycle SHALL return to IDLE; DEBOUNCE consecutive low cycles SHALL go to FRAME_X and set transmit_en=1 on the same edge.
REQ-019 Each frame SHALL be adc_cs_n=0 for exactly 24 adc_dclk periods; adc_cs_n SHALL fall CLK_DIV cycles before the first dclk rise and rise CLK_DIV cycles after the last dclk fall.
REQ-020 adc_dclk SHALL idle low and toggle every CLK_DIV sys_clk cycles inside a frame.
REQ-021 adc_din SHALL change only on dclk falling edges (first bit before the first rise), MSB first.
REQ-022 Command bytes SHALL be 8'hD0 for X and 8'h90 for Y; adc_din SHALL be 0 for dclk periods 9..24.
REQ-023 adc_dout SHALL be sampled on the sys_clk cycle that drives dclk high; the bits at dclk periods 10..21 form a 12-bit result, MSB first.
REQ-024 x_in SHALL be result_x[11:4].
REQ-025 y_in SHALL be result_y[11:2].
REQ-026 FRAME_X SHALL go to FRAME_Y with adc_cs_n high for CLK_DIV cycles between the frames.
REQ-027 FRAME_Y end SHALL go to UPDATE: x_in and y_in load together, and new_coord_r=1 for exactly one cycle.
REQ-028 UPDATE SHALL always go to GAP.
REQ-029 penirq_n SHALL be ignored during frames, because the ADC disturbs it.
REQ-030 GAP: after GAP cycles, penirq_n=0 SHALL go to FRAME_X with transmit_en held high.
REQ-031 GAP: after GAP cycles, penirq_n=1 SHALL go to IDLE and clear transmit_en on the same edge.
REQ-032 x_in/y_in SHALL hold their last values outside UPDATE; a pen release SHALL NOT clear them.
REQ-033 transmit_en SHALL have no glitches: one rising edge per session, one falling edge at session end.

Reset
REQ-034 While iRST_n=0, regardless of state or frame position, SHALL force and hold: state IDLE, adc_cs_n=1, adc_dclk=0, adc_din=0, transmit_en=0, new_coord_r=0, x_in=0, y_in=0, penirq_n=1, all counters 0.
REQ-035 After iRST_n rises, SHALL not start a frame until a full DEBOUNCE period has elapsed.

Verification
REQ-036 CLK_DIV=2, DEBOUNCE=8, GAP=16; pen held low; ADC model returns 12'hABC for X and 12'h5A5 for Y -> x_in=8'hAB, y_in=10'h169, one new_coord_r pulse per pair, transmit_en stays high.
REQ-037 Pen low for 5 cycles then high -> no adc_cs_n activity, transmit_en stays 0.
REQ-038 Pen released mid-FRAME_Y -> pair completes with a strobe, then transmit_en=0 exactly GAP+1 cycles after UPDATE, x_in/y_in retained.
REQ-039 Check adc_din bit pattern 11010000 then 16 zeros, and 10010000 then 16 zeros, against dclk edges; each frame has 24 dclk rises.
REQ-040 iRST_n pulsed low at dclk period 15 of FRAME_X -> all outputs at reset values immediately with no clock; a full debounce occurs before the next frame.
REQ-041 Results 12'hFFF and 12'h000 -> x_in=8'hFF/8'h00 and y_in=10'h3FF/10'h000, with no wrap.
